mantissa_div_seq: RTL and testbench

Sequential restoring divider for normalised floating-point significands, parametrised in mantissa width, with valid/ready handshakes, guard/sticky generation, round-to-nearest-even, and a divide-by-zero flag. It sits in the FPU divide path between operand unpacking (exponent subtract, sign XOR) and result packing. It returns the rounded fraction plus the two exponent-adjust bits the packer needs: exp = ea − eb + bias − norm_shift + exp_inc.

---
 rtl/fpu_div_pkg.sv | 37 +++
 rtl/mantissa_div_seq_if.sv | 55 +++++
 rtl/div_round_rne.sv | 62 ++++++
 rtl/mantissa_div_seq.sv | 175 +++++++++++++++++
 tb/tb_mantissa_div_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_div_pkg.sv
// ---------------------------------------------------------------------------
// fpu_div_pkg
//   Shared types and helpers for the FPU significand divide path.
//   - div_state_e  : sequencer states of the restoring divider
//   - qw()         : number of quotient bits produced for a significand width
//                    (integer bit + MW-1 fraction bits + hidden bit position +
//                    one guard bit, i.e. MW+2)
//   - div_result_t : result bundle handed to the packer, sized for the
//                    default (single precision) significand width
// ---------------------------------------------------------------------------
package fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  // Default significand width including the hidden bit (single precision).
  localparam int MW_DEFAULT = 32'sd24;

  // Quotient bits generated: integer bit, MW fraction bits, one guard bit.
  function automatic int qw(input int mw);
    return mw + 32'sd2;
  endfunction

  // Result bundle for the default width; field order matches the packer.
  typedef struct packed {
    logic [MW_DEFAULT-2:0] q_frac;
    logic                  norm_shift;
    logic                  exp_inc;
    logic                  inexact;
    logic                  div_by_zero;
  } div_result_t;

endpackage

// File: rtl/mantissa_div_seq_if.sv
// ---------------------------------------------------------------------------
// mantissa_div_seq_if
//   Operand and result handshakes of the sequential significand divider.
//   Operand side : in_valid / in_ready, dividend, divisor
//   Result side  : out_valid / out_ready, q_frac, norm_shift, exp_inc,
//                  inexact, div_by_zero
//   master modport : the producer of operands and consumer of results
//   slave modport  : the divider itself
// ---------------------------------------------------------------------------
interface mantissa_div_seq_if #(
  parameter int MW = 24
);

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] dividend;
  logic [MW-1:0] divisor;

  logic          out_valid;
  logic          out_ready;
  logic [MW-2:0] q_frac;
  logic          norm_shift;
  logic          exp_inc;
  logic          inexact;
  logic          div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q_frac,
    input  norm_shift,
    input  exp_inc,
    input  inexact,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q_frac,
    output norm_shift,
    output exp_inc,
    output inexact,
    output div_by_zero
  );

endinterface

// File: rtl/div_round_rne.sv
// ---------------------------------------------------------------------------
// div_round_rne
//   Purely combinational normalise + guard/sticky + round-to-nearest-even
//   stage. Takes a raw QW-bit quotient whose value lies in (0.5, 2) with the
//   binary point after the MSB, plus a flag telling whether any remainder is
//   left, and produces the rounded fraction (hidden bit dropped).
//   Also used by the square-root unit, so it carries no state.
//
//   Ports
//     q          in  QW   raw quotient, q[QW-1] has weight 1
//     rem_nz     in  1    remainder is nonzero (contributes to sticky)
//     frac       out MW-1 rounded fraction
//     norm_shift out 1    quotient was < 1, result shifted left by one
//     exp_inc    out 1    rounding carried out of the MW-bit significand
//     inexact    out 1    guard or sticky nonzero
// ---------------------------------------------------------------------------
module div_round_rne
  import fpu_div_pkg::*;
#(
  parameter int MW = 24
) (
  input  logic [qw(MW)-1:0] q,
  input  logic              rem_nz,
  output logic [MW-2:0]     frac,
  output logic              norm_shift,
  output logic              exp_inc,
  output logic              inexact
);

  localparam int QW = qw(MW);

  logic [MW-1:0] sig;
  logic          guard;
  logic          sticky;
  logic          round_up;

  // Normalise: pick the MW significand bits below the leading one and the
  // bit after them as guard; everything further down folds into sticky.
  always_comb begin
    if (q[QW-1]) begin
      sig        = q[QW-1:2];
      guard      = q[1];
      sticky     = q[0] | rem_nz;
      norm_shift = 1'b0;
    end else begin
      sig        = q[QW-2:1];
      guard      = q[0];
      sticky     = rem_nz;
      norm_shift = 1'b1;
    end
  end

  // Round to nearest even. The MW-bit increment only carries out when every
  // significand bit is one, in which case the wrapped fraction is zero.
  always_comb begin
    round_up = guard & (sticky | sig[0]);
    frac     = sig[MW-2:0] + {{(MW-2){1'b0}}, round_up};
    exp_inc  = round_up & (&sig);
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/mantissa_div_seq.sv
// ---------------------------------------------------------------------------
// mantissa_div_seq
//   Sequential restoring divider for normalised floating-point significands.
//   One quotient bit per clock for QW = MW+2 clocks, then one rounding clock,
//   then the result is held until the consumer accepts it. The packer forms
//   the exponent as ea - eb + bias - norm_shift + exp_inc.
//
//   Sequence : IDLE -> CALC (QW cycles) -> ROUND -> DONE -> IDLE
//              IDLE -> DONE directly when the divisor MSB is 0
//   Latency  : handshake in cycle 0, out_valid in cycle QW+2
//              (divide-by-zero: cycle 1)
//
//   Ports
//     clk   in  1  clock, all state on the rising edge
//     rstn  in  1  synchronous active-low reset
//     bus   slave  operand / result handshakes (see mantissa_div_seq_if)
// ---------------------------------------------------------------------------
module mantissa_div_seq
  import fpu_div_pkg::*;
#(
  parameter int MW = 24
) (
  input  logic              clk,
  input  logic              rstn,
  mantissa_div_seq_if.slave bus
);

  localparam int QW = qw(MW);
  localparam int CW = $clog2(QW);

  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CALC  = CALC;
  localparam logic [1:0] ST_ROUND = ROUND;
  localparam logic [1:0] ST_DONE  = DONE;

  // Sequencer and datapath state
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [MW:0]   rem;
  logic [MW-1:0] dsr;
  logic [QW-1:0] quo;

  // Registered handshake and result outputs
  logic          ready;
  logic          valid;
  logic [MW-2:0] res_frac;
  logic          res_norm;
  logic          res_inc;
  logic          res_inexact;
  logic          res_dbz;

  // Restoring step
  logic [MW+1:0] trial;
  logic          qbit;
  logic [MW:0]   rem_next;
  logic          rem_nz;

  // Rounding stage results
  logic [MW-2:0] rnd_frac;
  logic          rnd_norm;
  logic          rnd_inc;
  logic          rnd_inexact;

  // One restoring step: the trial difference carries an extra sign bit, and
  // is kept only when it did not go negative.
  always_comb begin
    trial  = {1'b0, rem} - {2'b00, dsr};
    rem_nz = |rem;
    if (trial[MW+1]) begin
      qbit     = 1'b0;
      rem_next = rem << 1'b1;
    end else begin
      qbit     = 1'b1;
      rem_next = trial[MW:0] << 1'b1;
    end
  end

  div_round_rne #(
    .MW (MW)
  ) u_round (
    .q          (quo),
    .rem_nz     (rem_nz),
    .frac       (rnd_frac),
    .norm_shift (rnd_norm),
    .exp_inc    (rnd_inc),
    .inexact    (rnd_inexact)
  );

  // Sequencer, remainder/quotient registers and result registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      dsr         <= '0;
      quo         <= '0;
      ready       <= 1'b1;
      valid       <= 1'b0;
      res_frac    <= '0;
      res_norm    <= 1'b0;
      res_inc     <= 1'b0;
      res_inexact <= 1'b0;
      res_dbz     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            rem   <= {1'b0, bus.dividend};
            dsr   <= bus.divisor;
            quo   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            if (!bus.divisor[MW-1]) begin
              // A divisor without its hidden bit is treated as zero.
              state       <= ST_DONE;
              valid       <= 1'b1;
              res_frac    <= '0;
              res_norm    <= 1'b0;
              res_inc     <= 1'b0;
              res_inexact <= 1'b0;
              res_dbz     <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          quo <= {quo[QW-2:0], qbit};
          rem <= rem_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= ST_ROUND;
          end
        end

        ST_ROUND: begin
          state       <= ST_DONE;
          valid       <= 1'b1;
          res_frac    <= rnd_frac;
          res_norm    <= rnd_norm;
          res_inc     <= rnd_inc;
          res_inexact <= rnd_inexact;
          res_dbz     <= 1'b0;
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
            valid <= 1'b0;
            ready <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid;
  assign bus.q_frac      = res_frac;
  assign bus.norm_shift  = res_norm;
  assign bus.exp_inc     = res_inc;
  assign bus.inexact     = res_inexact;
  assign bus.div_by_zero = res_dbz;

endmodule

// File: tb/tb_mantissa_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mantissa_div_seq
//   Self-checking bench for mantissa_div_seq with MW=24 and MW=53 instances.
//   Expected results are pushed to a queue when operands are driven and are
//   popped when out_valid is observed.
// ---------------------------------------------------------------------------
module tb_mantissa_div_seq;
  import fpu_div_pkg::*;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  mantissa_div_seq_if #(.MW(24)) bus24 ();
  mantissa_div_seq_if #(.MW(53)) bus53 ();

  mantissa_div_seq #(.MW(24)) dut24 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus24)
  );

  mantissa_div_seq #(.MW(53)) dut53 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus53)
  );

  int checks = 0;
  int errors = 0;

  div_result_t exp_q [$];

  // Test-plan vectors: 1.5/1.0, 1.0/1.5, x/x
  logic [23:0] a_tab [3] = '{24'hC00000, 24'h800000, 24'hABCDEF};
  logic [23:0] b_tab [3] = '{24'h800000, 24'hC00000, 24'hABCDEF};
  div_result_t e_tab [3] = '{div_result_t'({23'h400000, 4'b0000}),
                             div_result_t'({23'h2AAAAB, 4'b1010}),
                             div_result_t'({23'h000000, 4'b0000})};

  function automatic div_result_t obs24();
    return div_result_t'({bus24.q_frac, bus24.norm_shift, bus24.exp_inc,
                          bus24.inexact, bus24.div_by_zero});
  endfunction

  // Reference: exact integer quotient of a*2^25/b, then normalise and RNE.
  function automatic div_result_t model24(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] num;
    logic [63:0] qv;
    logic [63:0] rv;
    logic [23:0] sig;
    logic        g, s, ns, up;
    logic [24:0] sum;
    if (!b[23]) return div_result_t'({23'h0, 4'b0001});
    num = {40'h0, a} << 25;
    qv  = num / {40'h0, b};
    rv  = num % {40'h0, b};
    if (qv[25]) begin
      sig = qv[25:2]; g = qv[1]; s = qv[0] | (rv != 64'h0); ns = 1'b0;
    end else begin
      sig = qv[24:1]; g = qv[0]; s = (rv != 64'h0); ns = 1'b1;
    end
    up  = g & (s | sig[0]);
    sum = {1'b0, sig} + {24'h0, up};
    return div_result_t'({sum[22:0], ns, sum[24], g | s, 1'b0});
  endfunction

  // Drive one operand pair; caller is positioned at a negedge with in_ready high.
  task automatic send24(input logic [23:0] a, input logic [23:0] b);
    bus24.dividend = a;
    bus24.divisor  = b;
    bus24.in_valid = 1'b1;
    @(posedge clk);
    #1 bus24.in_valid = 1'b0;
  endtask

  // Count negedges until out_valid is seen or the limit expires.
  task automatic wait_valid24(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus24.out_valid !== 1'b1 && n < limit);
  endtask

  // Accept the pending result and move to the first IDLE cycle.
  task automatic accept24();
    bus24.out_ready = 1'b1;
    @(posedge clk);
    #1 bus24.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus24.in_valid = 1'b0; bus24.out_ready = 1'b0;
    bus24.dividend = 24'h0; bus24.divisor = 24'h0;
    bus53.in_valid = 1'b0; bus53.out_ready = 1'b0;
    bus53.dividend = 53'h0; bus53.divisor = 53'h0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus24.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", bus24.in_ready);
    end
    checks++;
    if (bus24.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", bus24.out_valid);
    end
    checks++;
    if (obs24() !== div_result_t'(27'h0)) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", obs24());
    end
    checks++;
    if (bus53.in_ready !== 1'b1 || bus53.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mw53 got rdy %b vld %b exp 1 0", bus53.in_ready, bus53.out_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    div_result_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e_tab[i]);
      send24(a_tab[i], b_tab[i]);
      wait_valid24(60, n);
      checks++;
      if (n != 28 || bus24.out_valid !== 1'b1) begin
        errors++; $display("FAIL basic_latency[%0d] got %0d exp 28", i, n);
      end
      checks++;
      if (bus24.in_ready !== 1'b0) begin
        errors++; $display("FAIL basic_in_ready[%0d] got %b exp 0", i, bus24.in_ready);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs24() !== e) begin
        errors++; $display("FAIL basic_result[%0d] got %h exp %h", i, obs24(), e);
      end
      accept24();
    end
  endtask

  task automatic test_div_zero();
    int n;
    div_result_t e;
    logic [23:0] dz [2] = '{24'h000000, 24'h7FFFFF};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(div_result_t'({23'h0, 4'b0001}));
      send24(24'hC00000, dz[i]);
      wait_valid24(60, n);
      checks++;
      if (n != 1 || bus24.out_valid !== 1'b1) begin
        errors++; $display("FAIL dbz_latency[%0d] got %0d exp 1", i, n);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs24() !== e) begin
        errors++; $display("FAIL dbz_result[%0d] got %h exp %h", i, obs24(), e);
      end
      accept24();
    end
  endtask

  task automatic test_backpressure();
    int n;
    div_result_t e;
    exp_q.push_back(e_tab[0]);
    send24(a_tab[0], b_tab[0]);
    wait_valid24(60, n);
    e = exp_q.pop_front();
    // Offer a divide-by-zero while busy; it must be ignored.
    bus24.dividend = 24'h800000; bus24.divisor = 24'h000000; bus24.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus24.out_valid !== 1'b1 || bus24.in_ready !== 1'b0 || obs24() !== e) begin
        errors++;
        $display("FAIL hold[%0d] got vld %b rdy %b res %h exp 1 0 %h",
                 k, bus24.out_valid, bus24.in_ready, obs24(), e);
      end
      @(negedge clk);
    end
    bus24.in_valid = 1'b0;
    accept24();
    checks++;
    if (bus24.out_valid !== 1'b0 || bus24.in_ready !== 1'b1) begin
      errors++; $display("FAIL after_accept got vld %b rdy %b exp 0 1", bus24.out_valid, bus24.in_ready);
    end
    // New operands in the first IDLE cycle; noise on in_valid during CALC.
    exp_q.push_back(e_tab[1]);
    send24(a_tab[1], b_tab[1]);
    bus24.dividend = 24'hFFFFFF; bus24.divisor = 24'h000000; bus24.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus24.in_valid = 1'b0;
    wait_valid24(60, n);
    checks++;
    if (n + 5 != 28) begin
      errors++; $display("FAIL reaccept_latency got %0d exp 28", n + 5);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs24() !== e) begin
      errors++; $display("FAIL reaccept_result got %h exp %h", obs24(), e);
    end
    accept24();
  endtask

  task automatic test_reset_abort();
    int n;
    bit stale;
    div_result_t e;
    send24(a_tab[0], b_tab[0]);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus24.in_ready !== 1'b1 || bus24.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_handshake got rdy %b vld %b exp 1 0", bus24.in_ready, bus24.out_valid);
    end
    checks++;
    if (obs24() !== div_result_t'(27'h0)) begin
      errors++; $display("FAIL abort_outputs got %h exp 0", obs24());
    end
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus24.out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++; $display("FAIL abort_stale got out_valid 1 exp 0");
    end
    exp_q.push_back(e_tab[0]);
    send24(a_tab[0], b_tab[0]);
    wait_valid24(60, n);
    checks++;
    if (n != 28 || bus24.out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_fresh_latency got %0d exp 28", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs24() !== e) begin
      errors++; $display("FAIL abort_fresh_result got %h exp %h", obs24(), e);
    end
    accept24();
  endtask

  task automatic test_back_to_back();
    int n;
    time t_prev, t_now;
    div_result_t e;
    logic [23:0] a, b;
    bus24.out_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin a = 24'hFFFFFF; b = 24'h800000; end
        1: begin a = 24'hFFFFFE; b = 24'hFFFFFF; end
        2: begin a = 24'h800000; b = 24'hFFFFFF; end
        default: begin
          a = 24'h800000 | 24'($urandom);
          b = 24'h800000 | 24'($urandom);
        end
      endcase
      exp_q.push_back(model24(a, b));
      send24(a, b);
      t_now = $time;
      if (k > 0) begin
        checks++;
        if (t_now - t_prev != 290) begin
          errors++; $display("FAIL b2b_period[%0d] got %0t exp 290", k, t_now - t_prev);
        end
      end
      t_prev = t_now;
      wait_valid24(60, n);
      checks++;
      if (n != 28 || bus24.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_latency[%0d] got %0d exp 28", k, n);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs24() !== e) begin
        errors++; $display("FAIL b2b_result[%0d] a %h b %h got %h exp %h", k, a, b, obs24(), e);
      end
      @(negedge clk);
      checks++;
      if (bus24.in_ready !== 1'b1 || bus24.out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle[%0d] got rdy %b vld %b exp 1 0", k, bus24.in_ready, bus24.out_valid);
      end
    end
    bus24.out_ready = 1'b0;
  endtask

  task automatic test_mw53();
    int n;
    bus53.dividend = 53'h18000000000000;
    bus53.divisor  = 53'h10000000000000;
    bus53.in_valid = 1'b1;
    @(posedge clk);
    #1 bus53.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus53.out_valid !== 1'b1 && n < 100);
    checks++;
    if (n != 57 || bus53.out_valid !== 1'b1) begin
      errors++; $display("FAIL mw53_latency got %0d exp 57", n);
    end
    checks++;
    if (bus53.q_frac !== 52'h8000000000000 || bus53.norm_shift !== 1'b0 ||
        bus53.exp_inc !== 1'b0 || bus53.inexact !== 1'b0 || bus53.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL mw53_result got %h %b%b%b%b exp 8000000000000 0000", bus53.q_frac,
               bus53.norm_shift, bus53.exp_inc, bus53.inexact, bus53.div_by_zero);
    end
    bus53.out_ready = 1'b1;
    @(posedge clk);
    #1 bus53.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus53.out_valid !== 1'b0 || bus53.in_ready !== 1'b1) begin
      errors++; $display("FAIL mw53_accept got vld %b rdy %b exp 0 1", bus53.out_valid, bus53.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_mw53();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
